// File: rtl/usb_reg_bridge_pkg.sv
// Shared definitions for the USB external-bus register bridge:
// bus geometry defaults and FSM state encoding.
package usb_reg_bridge_pkg;

    localparam int ADDR_WIDTH_DEF   = 21;
    localparam int BYTECNT_SIZE_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR      = 2'd1,
        ST_WR_PULSE  = 2'd2,
        ST_RD_ACTIVE = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/usb_reg_bridge_if.sv
// Bus-side and register-side signals of the bridge. The slave modport is the
// bridge's view; master is the surrounding environment (host bus + reg block).
interface usb_reg_bridge_if import usb_reg_bridge_pkg::*; #(
    parameter int pADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEF
);
    logic [pADDR_WIDTH-1:0]               usb_addr;
    logic [7:0]                           usb_din;
    logic [7:0]                           usb_dout;
    logic                                 usb_isout;
    logic                                 usb_cen;
    logic                                 usb_alen;
    logic                                 usb_wrn;
    logic                                 usb_rdn;
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
    logic [7:0]                           write_data;
    logic [7:0]                           read_data;
    logic                                 reg_read;
    logic                                 reg_write;
    logic                                 reg_addrvalid;
    logic                                 proto_err;

    modport slave (
        input  usb_addr, usb_din, usb_cen, usb_alen, usb_wrn, usb_rdn, read_data,
        output usb_dout, usb_isout, reg_address, reg_bytecnt, write_data,
               reg_read, reg_write, reg_addrvalid, proto_err
    );

    modport master (
        output usb_addr, usb_din, usb_cen, usb_alen, usb_wrn, usb_rdn, read_data,
        input  usb_dout, usb_isout, reg_address, reg_bytecnt, write_data,
               reg_read, reg_write, reg_addrvalid, proto_err
    );

endinterface

// File: rtl/usb_reg_bridge_edge_det.sv
// Two-stage strobe register with fall/rise detection. A strobe already away
// from its idle level when reset releases is absorbed without an edge.
module usb_edge_det #(
    parameter logic pIDLE_LVL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic sig_r_o,
    output logic fall_o,
    output logic rise_o
);
    logic s1_q;
    logic s2_q;
    logic armed_q;

    // Until the first post-reset clock, the second stage loads straight from
    // the pin so both stages agree and no spurious edge appears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= pIDLE_LVL;
            s2_q    <= pIDLE_LVL;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= sig_i;
            s2_q    <= armed_q ? s1_q : sig_i;
            armed_q <= 1'b1;
        end
    end

    assign sig_r_o = s1_q;
    assign fall_o  = s2_q & ~s1_q;
    assign rise_o  = ~s2_q & s1_q;

endmodule

// File: rtl/usb_reg_bridge.sv
// Bridges the asynchronous USB external bus (cen/alen/wrn/rdn strobes) onto a
// synchronous register port with auto-incrementing byte counter.
//
// state        | meaning
// ST_IDLE      | chip not selected, waiting for an address latch
// ST_ADDR      | address valid, waiting for a read or write strobe
// ST_WR_PULSE  | one-cycle reg_write pulse, byte counter advances on exit
// ST_RD_ACTIVE | read in progress, bus driven while rdn stays low
module usb_reg_bridge import usb_reg_bridge_pkg::*; #(
    parameter int pADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int pBYTECNT_SIZE = BYTECNT_SIZE_DEF
) (
    input  logic             usb_clk,
    input  logic             reset_i,
    usb_reg_bridge_if.slave  bus
);
    localparam int RA_W = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam logic [pBYTECNT_SIZE-1:0] BC_ONE = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

    logic [pADDR_WIDTH-1:0]   addr_r_q;
    logic [7:0]               din_r_q;
    logic                     cen_r_q;
    logic                     alen_r_q;
    logic                     wrn_r, wr_fall, wr_rise_unused;
    logic                     rdn_r, rd_fall, rd_rise;
    logic                     both_low;

    bridge_state_e            state_q, state_d;
    logic [RA_W-1:0]          reg_address_q, reg_address_d;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q, reg_bytecnt_d;
    logic [7:0]               write_data_q, write_data_d;
    logic [7:0]               dout_q, dout_d;
    logic                     reg_read_q, reg_read_d;
    logic                     reg_write_q, reg_write_d;
    logic                     isout_q, isout_d;
    logic                     addrvalid_q, addrvalid_d;
    logic                     proto_err_q, proto_err_d;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            addr_r_q <= '0;
            din_r_q  <= '0;
            cen_r_q  <= 1'b1;
            alen_r_q <= 1'b1;
        end else begin
            addr_r_q <= bus.usb_addr;
            din_r_q  <= bus.usb_din;
            cen_r_q  <= bus.usb_cen;
            alen_r_q <= bus.usb_alen;
        end
    end

    usb_edge_det #(.pIDLE_LVL(1'b1)) u_wrn_det (
        .clk_i   (usb_clk),
        .rst_i   (reset_i),
        .sig_i   (bus.usb_wrn),
        .sig_r_o (wrn_r),
        .fall_o  (wr_fall),
        .rise_o  (wr_rise_unused)
    );

    usb_edge_det #(.pIDLE_LVL(1'b1)) u_rdn_det (
        .clk_i   (usb_clk),
        .rst_i   (reset_i),
        .sig_i   (bus.usb_rdn),
        .sig_r_o (rdn_r),
        .fall_o  (rd_fall),
        .rise_o  (rd_rise)
    );

    assign both_low = ~wrn_r & ~rdn_r;

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            reg_address_q <= '0;
            reg_bytecnt_q <= '0;
            write_data_q  <= '0;
            dout_q        <= '0;
            reg_read_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            isout_q       <= 1'b0;
            addrvalid_q   <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            reg_address_q <= reg_address_d;
            reg_bytecnt_q <= reg_bytecnt_d;
            write_data_q  <= write_data_d;
            dout_q        <= dout_d;
            reg_read_q    <= reg_read_d;
            reg_write_q   <= reg_write_d;
            isout_q       <= isout_d;
            addrvalid_q   <= addrvalid_d;
            proto_err_q   <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cen_r_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!alen_r_q) state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if (alen_r_q && !both_low) begin
                        if (wr_fall)      state_d = ST_WR_PULSE;
                        else if (rd_fall) state_d = ST_RD_ACTIVE;
                    end
                end
                ST_WR_PULSE: state_d = ST_ADDR;
                ST_RD_ACTIVE: begin
                    if (!wrn_r || rd_rise) state_d = ST_ADDR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_address_d = reg_address_q;
        reg_bytecnt_d = reg_bytecnt_q;
        write_data_d  = write_data_q;
        dout_d        = (state_q == ST_RD_ACTIVE) ? bus.read_data : dout_q;
        reg_read_d    = reg_read_q;
        reg_write_d   = 1'b0;
        isout_d       = isout_q;
        addrvalid_d   = addrvalid_q;
        proto_err_d   = proto_err_q;
        if (cen_r_q) begin
            reg_read_d  = 1'b0;
            isout_d     = 1'b0;
            addrvalid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!alen_r_q) begin
                        reg_address_d = addr_r_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt_d = addr_r_q[pBYTECNT_SIZE-1:0];
                        addrvalid_d   = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (!alen_r_q) begin
                        reg_address_d = addr_r_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt_d = addr_r_q[pBYTECNT_SIZE-1:0];
                    end else if (both_low) begin
                        proto_err_d = 1'b1;
                    end else if (wr_fall) begin
                        write_data_d = din_r_q;
                        reg_write_d  = 1'b1;
                    end else if (rd_fall) begin
                        reg_read_d = 1'b1;
                        isout_d    = 1'b1;
                    end
                end
                ST_WR_PULSE: begin
                    reg_bytecnt_d = reg_bytecnt_q + BC_ONE;
                    if (both_low) proto_err_d = 1'b1;
                end
                ST_RD_ACTIVE: begin
                    // Any write activity during a read aborts it without advancing.
                    if (!wrn_r) begin
                        proto_err_d = 1'b1;
                        reg_read_d  = 1'b0;
                        isout_d     = 1'b0;
                    end else if (rd_rise) begin
                        reg_read_d    = 1'b0;
                        isout_d       = 1'b0;
                        reg_bytecnt_d = reg_bytecnt_q + BC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // The drive enable is gated by the live registered strobes so the bus is
    // released as soon as cen or rdn go high, not a cycle later.
    assign bus.usb_isout     = isout_q & ~cen_r_q & ~rdn_r;
    assign bus.usb_dout      = dout_q;
    assign bus.reg_address   = reg_address_q;
    assign bus.reg_bytecnt   = reg_bytecnt_q;
    assign bus.write_data    = write_data_q;
    assign bus.reg_read      = reg_read_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.reg_addrvalid = addrvalid_q;
    assign bus.proto_err     = proto_err_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge: address latch, write bursts with byte
// counter wrap, read latency, protocol errors, reset abort and chip deselect.
module tb_usb_reg_bridge;
    import usb_reg_bridge_pkg::*;

    localparam int AW = 21;
    localparam int BW = 7;

    logic usb_clk = 1'b0;
    logic reset_i = 1'b1;

    usb_reg_bridge_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) bif ();

    usb_reg_bridge #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) dut (
        .usb_clk (usb_clk),
        .reset_i (reset_i),
        .bus     (bif.slave)
    );

    always #5 usb_clk = ~usb_clk;

    // Register-block stub: data valid one cycle after reg_read.
    always @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) bif.read_data <= 8'h00;
        else         bif.read_data <= bif.reg_read ? 8'h41 : 8'h00;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       rd_prev = 1'b0;
    logic [6:0] bc_log [16];
    logic [7:0] wd_log [16];

    always @(negedge usb_clk) begin
        if (bif.reg_write) begin
            if (wr_cnt < 16) begin
                bc_log[wr_cnt] = bif.reg_bytecnt;
                wd_log[wr_cnt] = bif.write_data;
            end
            wr_cnt++;
        end
        if (bif.reg_read && !rd_prev) rd_cnt++;
        rd_prev = bif.reg_read;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge usb_clk);
    endtask

    task automatic latch(input logic [AW-1:0] a);
        bif.usb_cen  = 1'b0;
        bif.usb_addr = a;
        bif.usb_alen = 1'b0;
        tick();
        bif.usb_alen = 1'b1;
        tick(2);
    endtask

    task automatic bus_write(input logic [7:0] d);
        bif.usb_din = d;
        bif.usb_wrn = 1'b0;
        tick(3);
        bif.usb_wrn = 1'b1;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int r0;
        logic [6:0] exp_bc [3];
        logic [7:0] exp_wd [3];
        exp_bc[0] = 7'd126; exp_bc[1] = 7'd127; exp_bc[2] = 7'd0;
        exp_wd[0] = 8'h11;  exp_wd[1] = 8'h22;  exp_wd[2] = 8'h33;

        bif.usb_addr = '0;
        bif.usb_din  = '0;
        bif.usb_cen  = 1'b1;
        bif.usb_alen = 1'b1;
        bif.usb_wrn  = 1'b1;
        bif.usb_rdn  = 1'b1;
        tick(2);
        chk("rst_flags", {bif.reg_read, bif.reg_write, bif.usb_isout, bif.reg_addrvalid, bif.proto_err}, 0);
        chk("rst_addr", bif.reg_address, 0);
        chk("rst_data", {bif.usb_dout, bif.write_data, 1'b0, bif.reg_bytecnt}, 0);
        reset_i = 1'b0;
        tick(2);

        // single write
        latch(21'h0C000);
        chk("latch_addr", bif.reg_address, 14'h180);
        chk("latch_bc", bif.reg_bytecnt, 0);
        chk("latch_valid", bif.reg_addrvalid, 1);
        w0 = wr_cnt;
        bus_write(8'hA5);
        chk("wr1_pulses", wr_cnt - w0, 1);
        chk("wr1_data", wd_log[w0], 8'hA5);
        chk("wr1_bc", bc_log[w0], 0);
        chk("wr1_bc_after", bif.reg_bytecnt, 1);

        // burst across the byte-counter wrap
        latch(21'h0C07E);
        chk("wrap_latch_bc", bif.reg_bytecnt, 126);
        w0 = wr_cnt;
        bus_write(8'h11);
        bus_write(8'h22);
        bus_write(8'h33);
        chk("wrap_pulses", wr_cnt - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_bc%0d", i), bc_log[w0+i], exp_bc[i]);
            chk($sformatf("wrap_wd%0d", i), wd_log[w0+i], exp_wd[i]);
        end
        chk("wrap_addr", bif.reg_address, 14'h180);
        chk("wrap_bc_after", bif.reg_bytecnt, 1);

        // read latency and bus release
        latch(21'h00285);
        chk("rd_latch_addr", bif.reg_address, 14'h005);
        chk("rd_latch_bc", bif.reg_bytecnt, 5);
        r0 = rd_cnt;
        bif.usb_rdn = 1'b0;
        tick(2);
        chk("rd_read_hi", bif.reg_read, 1);
        chk("rd_isout_hi", bif.usb_isout, 1);
        tick();
        chk("rd_dout_early", bif.usb_dout, 8'h00);
        tick();
        chk("rd_dout", bif.usb_dout, 8'h41);
        bif.usb_rdn = 1'b1;
        tick();
        chk("rd_isout_lo", bif.usb_isout, 0);
        tick();
        chk("rd_read_lo", bif.reg_read, 0);
        chk("rd_pulses", rd_cnt - r0, 1);
        chk("rd_bc_after", bif.reg_bytecnt, 6);

        // simultaneous strobes
        chk("perr_clear", bif.proto_err, 0);
        w0 = wr_cnt;
        r0 = rd_cnt;
        bif.usb_wrn = 1'b0;
        bif.usb_rdn = 1'b0;
        tick(4);
        chk("perr_set", bif.proto_err, 1);
        chk("perr_isout", bif.usb_isout, 0);
        bif.usb_wrn = 1'b1;
        bif.usb_rdn = 1'b1;
        tick(4);
        chk("perr_no_wr", wr_cnt - w0, 0);
        chk("perr_no_rd", rd_cnt - r0, 0);
        bus_write(8'h3C);
        chk("perr_sticky", bif.proto_err, 1);

        // reset in the middle of a read
        latch(21'h00300);
        bif.usb_rdn = 1'b0;
        tick(2);
        chk("rrst_read_hi", bif.reg_read, 1);
        reset_i = 1'b1;
        #1;
        chk("rrst_flags", {bif.reg_read, bif.reg_write, bif.usb_isout, bif.reg_addrvalid, bif.proto_err}, 0);
        chk("rrst_addr", bif.reg_address, 0);
        chk("rrst_data", {bif.usb_dout, bif.write_data, 1'b0, bif.reg_bytecnt}, 0);
        tick(2);
        reset_i = 1'b0;
        r0 = rd_cnt;
        tick(5);
        chk("rrst_no_rd", rd_cnt - r0, 0);
        chk("rrst_read_lo", bif.reg_read, 0);
        bif.usb_rdn = 1'b1;
        tick(3);

        // chip deselect mid-burst
        latch(21'h0C000);
        bus_write(8'h5A);
        chk("cen_bc_before", bif.reg_bytecnt, 1);
        bif.usb_cen = 1'b1;
        tick(2);
        chk("cen_valid_lo", bif.reg_addrvalid, 0);
        chk("cen_bc_held", bif.reg_bytecnt, 1);
        chk("cen_addr_held", bif.reg_address, 14'h180);
        bif.usb_cen = 1'b0;
        w0 = wr_cnt;
        bus_write(8'h66);
        chk("cen_wr_ignored", wr_cnt - w0, 0);
        chk("cen_bc_still", bif.reg_bytecnt, 1);
        latch(21'h0C000);
        chk("cen_relatch_valid", bif.reg_addrvalid, 1);
        w0 = wr_cnt;
        bus_write(8'h77);
        chk("cen_wr_resumed", wr_cnt - w0, 1);
        chk("cen_wr_data", bif.write_data, 8'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
